// File: rtl/line_buffer_pkg.sv
// Shared constants, FSM state type and the transparency test for line_buffer.
package line_buffer_pkg;

  localparam int unsigned LINE_W    = 256;
  localparam int unsigned HBL_START = 256;

  // Low nibble of a pixel word selects transparency; all-zero means "no pixel".
  localparam int unsigned           TRANSP_W    = 4;
  localparam logic [TRANSP_W-1:0]   TRANSP_MASK = 4'hF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } lb_state_e;

  function automatic logic is_transparent(input logic [TRANSP_W-1:0] low);
    return (low & TRANSP_MASK) == '0;
  endfunction

endpackage

// File: rtl/line_buffer_dpram_256.sv
// True dual-port RAM, one bank of the line buffer, 1-clk read latency.
// Ports (each of a/b): en, we, addr, wdata, rdata. Reads return the old
// contents when the same port writes in the same clk.
module dpram_256 #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Both ports in one process so the array has a single driver.
  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem[a_addr] <= a_wdata;
      a_rdata <= mem[a_addr];
    end
    if (b_en) begin
      if (b_we) mem[b_addr] <= b_wdata;
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/line_buffer.sv
// Double-banked scanline buffer. The renderer draws into one bank with a
// first-opaque-wins read-modify-write while the other bank is streamed to the
// display and cleared behind the reader. Banks swap at the start of hblank.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   clk_pix, hc, hbl    pixel enable, horizontal count, horizontal blank
//   wr_valid/wr_ready   renderer write handshake, wr_x/wr_data its payload
//   line_start          one-clk pulse after the swap
//   pix_out             display pixel
module line_buffer #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LINE_W = line_buffer_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_pix,
  input  logic [8:0]        hc,
  input  logic              hbl,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [8:0]        wr_x,
  input  logic [DATA_W-1:0] wr_data,
  output logic              line_start,
  output logic [DATA_W-1:0] pix_out
);

  import line_buffer_pkg::*;

  localparam int unsigned     ADDR_W   = $clog2(LINE_W);
  localparam int unsigned     CLR_W    = ADDR_W + 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(2 * LINE_W - 1);

  lb_state_e         state;
  logic [CLR_W-1:0]  clr_addr;
  logic              disp_bank;

  // Reader: read on a tick, capture + clear on the following clk.
  logic              rd_pend;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              hold_vld;
  logic [DATA_W-1:0] pix_hold;

  // Writer stage 1 (RAM read in flight) and last committed write (forward source).
  logic              s1_vld, s1_bank;
  logic [ADDR_W-1:0] s1_x;
  logic [DATA_W-1:0] s1_data;
  logic              s2_vld, s2_bank;
  logic [ADDR_W-1:0] s2_x;
  logic [DATA_W-1:0] s2_data;

  logic [DATA_W-1:0] rdata_a [2];
  logic [DATA_W-1:0] rdata_b [2];

  logic              run_c, swap_c, rd_tick_c, accept_c, keep_c, commit_c;
  logic [DATA_W-1:0] stored_c;

  always_comb begin
    run_c     = (state == ST_RUN);
    swap_c    = run_c && clk_pix && (hc == 9'(HBL_START));
    rd_tick_c = run_c && clk_pix && (32'(hc) < LINE_W);
    accept_c  = wr_valid && wr_ready;
    keep_c    = accept_c && (32'(wr_x) < LINE_W)
                && !is_transparent(wr_data[TRANSP_W-1:0]);
    // A commit on the previous clk is not yet visible to the RAM read.
    stored_c  = (s2_vld && (s2_bank == s1_bank) && (s2_x == s1_x))
                ? s2_data : rdata_b[s1_bank];
    commit_c  = s1_vld && is_transparent(stored_c[TRANSP_W-1:0]);
  end

  // Port A: clear FSM, writer commit, reader read/clear. Commits target the
  // tagged bank; after a swap that bank is the display bank, but the reader is
  // idle through hblank so the two never meet. Port B: writer lookup only.
  for (genvar g = 0; g < 2; g++) begin : g_bank
    logic              a_en, a_we, b_en;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;

    always_comb begin
      a_en    = 1'b0;
      a_we    = 1'b0;
      a_addr  = '0;
      a_wdata = '0;
      b_en    = keep_c && (disp_bank != 1'(g));
      if (!run_c) begin
        if (clr_addr[CLR_W-1] == 1'(g)) begin
          a_en   = 1'b1;
          a_we   = 1'b1;
          a_addr = clr_addr[ADDR_W-1:0];
        end
      end else if (commit_c && (s1_bank == 1'(g))) begin
        a_en    = 1'b1;
        a_we    = 1'b1;
        a_addr  = s1_x;
        a_wdata = s1_data;
      end else if (rd_tick_c && (disp_bank == 1'(g))) begin
        a_en   = 1'b1;
        a_addr = hc[ADDR_W-1:0];
      end else if (rd_pend && (rd_bank == 1'(g))) begin
        a_en   = 1'b1;
        a_we   = 1'b1;
        a_addr = rd_addr;
      end
    end

    dpram_256 #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk     (clk),
      .a_en    (a_en),
      .a_we    (a_we),
      .a_addr  (a_addr),
      .a_wdata (a_wdata),
      .a_rdata (rdata_a[g]),
      .b_en    (b_en),
      .b_we    (1'b0),
      .b_addr  (wr_x[ADDR_W-1:0]),
      .b_wdata ({DATA_W{1'b0}}),
      .b_rdata (rdata_b[g])
    );
  end

  // Control, reader pipeline, writer pipeline and CLEAR -> RUN FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      disp_bank  <= 1'b0;
      pix_out    <= '0;
      line_start <= 1'b0;
      wr_ready   <= 1'b0;
      rd_pend    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      hold_vld   <= 1'b0;
      pix_hold   <= '0;
      s1_vld     <= 1'b0;
      s1_bank    <= 1'b0;
      s1_x       <= '0;
      s1_data    <= '0;
      s2_vld     <= 1'b0;
      s2_bank    <= 1'b0;
      s2_x       <= '0;
      s2_data    <= '0;
    end else begin
      line_start <= swap_c;
      if (swap_c) disp_bank <= ~disp_bank;

      if (clk_pix) begin
        if (hold_vld) begin
          pix_out  <= pix_hold;
          hold_vld <= 1'b0;
        end else if (hbl) begin
          pix_out <= '0;
        end
      end

      rd_pend <= rd_tick_c;
      if (rd_tick_c) begin
        rd_bank <= disp_bank;
        rd_addr <= hc[ADDR_W-1:0];
      end
      if (rd_pend) begin
        hold_vld <= 1'b1;
        pix_hold <= rdata_a[rd_bank];
      end

      s1_vld <= keep_c;
      if (keep_c) begin
        s1_bank <= ~disp_bank;
        s1_x    <= wr_x[ADDR_W-1:0];
        s1_data <= wr_data;
      end
      s2_vld <= commit_c;
      if (commit_c) begin
        s2_bank <= s1_bank;
        s2_x    <= s1_x;
        s2_data <= s1_data;
      end

      case (state)
        ST_CLEAR: begin
          wr_ready <= 1'b0;
          clr_addr <= clr_addr + CLR_W'(1);
          if (clr_addr == CLR_LAST) begin
            state    <= ST_RUN;
            wr_ready <= 1'b1;
          end
        end
        ST_RUN:  wr_ready <= !swap_c;
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer: drives a free-running pixel timing
// (clk_pix every other clk, hc 0..383) and checks displayed lines.
module tb_line_buffer;

  localparam int unsigned DW = 12;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          clk_pix  = 1'b0;
  logic [8:0]    hc       = '0;
  logic          hbl      = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [8:0]    wr_x     = '0;
  logic [DW-1:0] wr_data  = '0;
  logic          line_start;
  logic [DW-1:0] pix_out;

  always #5 clk = ~clk;

  line_buffer #(.DATA_W(DW), .LINE_W(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_pix    (clk_pix),
    .hc         (hc),
    .hbl        (hbl),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_data    (wr_data),
    .line_start (line_start),
    .pix_out    (pix_out)
  );

  typedef struct { int x; logic [DW-1:0] d;   } wvec_t;
  typedef struct { int x; logic [DW-1:0] exp; } pvec_t;

  wvec_t         wv [12];
  pvec_t         pv [10];
  logic [DW-1:0] cap [256];
  logic [DW-1:0] dk [24];
  bit            acc_k [24];

  int total = 0;
  int bad   = 0;
  bit acc;
  bit last_tick;
  int last_hc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One clk: note handshake and tick before the edge, advance timing after.
  task automatic cyc();
    acc       = wr_valid && wr_ready;
    last_tick = clk_pix;
    last_hc   = int'(hc);
    @(posedge clk);
    #1;
    if (clk_pix) hc = (hc == 9'd383) ? 9'd0 : hc + 9'd1;
    clk_pix = !clk_pix;
    hbl     = (hc >= 9'd256);
  endtask

  task automatic wait_tick(input int h);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(last_tick && last_hc == h) && n < 2000);
    if (!(last_tick && last_hc == h)) begin
      total++;
      bad++;
      $display("FAIL wait_tick_%0d: got timeout want tick", h);
    end
  endtask

  task automatic send(input int x, input logic [DW-1:0] d, output int cycles);
    wr_valid = 1'b1;
    wr_x     = 9'(x);
    wr_data  = d;
    cycles   = 0;
    do begin
      cyc();
      cycles++;
    end while (!acc && cycles < 50);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_x%0d: got no accept want accept", x);
    end
  endtask

  // Pixel x appears on pix_out right after the tick with hc == x+1.
  task automatic capture_line();
    for (int x = 0; x < 256; x++) begin
      wait_tick(x + 1);
      cap[x] = pix_out;
    end
  endtask

  function automatic int count_nonzero();
    int m;
    m = 0;
    for (int x = 0; x < 256; x++) if (cap[x] !== '0) m++;
    return m;
  endfunction

  task automatic wait_clear(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!wr_ready && n < 3000);
  endtask

  initial begin
    int n, c, s, m, rl_cnt, ls_cnt, rl_idx, ls_idx;
    logic [DW-1:0] e;

    wv[0]  = '{10,  12'h123};
    wv[1]  = '{5,   12'h0A1};
    wv[2]  = '{5,   12'h0B2};
    wv[3]  = '{7,   12'h120};
    wv[4]  = '{7,   12'h3C4};
    wv[5]  = '{300, 12'h155};
    wv[6]  = '{8,   12'h0F1};
    wv[7]  = '{9,   12'h222};
    wv[8]  = '{8,   12'h333};
    wv[9]  = '{0,   12'h011};
    wv[10] = '{255, 12'h7FF};
    wv[11] = '{200, 12'h5A0};

    pv[0] = '{10,  12'h123};
    pv[1] = '{5,   12'h0A1};
    pv[2] = '{7,   12'h3C4};
    pv[3] = '{8,   12'h0F1};
    pv[4] = '{9,   12'h222};
    pv[5] = '{0,   12'h011};
    pv[6] = '{255, 12'h7FF};
    pv[7] = '{200, 12'h000};
    pv[8] = '{44,  12'h000};
    pv[9] = '{11,  12'h000};

    // Reset state and CLEAR length.
    repeat (5) cyc();
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_line_start", 32'(line_start), 0);
    chk("rst_pix_out", 32'(pix_out), 0);
    reset = 1'b0;
    wait_clear(n);
    chk("clear_len", n, 512);

    wait_tick(256);
    capture_line();
    chk("first_line_zero", count_nonzero(), 0);

    // Table of back-to-back writes, then the next displayed line.
    wait_tick(20);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      send(wv[i].x, wv[i].d, c);
      n += c;
    end
    wr_valid = 1'b0;
    chk("no_stall_cycles", n, 12);
    wait_tick(256);
    capture_line();
    for (int i = 0; i < 10; i++)
      chk($sformatf("pix_x%0d", pv[i].x), 32'(cap[pv[i].x]), 32'(pv[i].exp));
    capture_line();
    chk("line2_pix_x10", 32'(cap[10]), 0);
    chk("line2_empty", count_nonzero(), 0);

    // wr_valid held across the swap, a new x and data every clk.
    wait_tick(250);
    s = -1; rl_cnt = 0; ls_cnt = 0; rl_idx = -1; ls_idx = -1;
    wr_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      dk[k]   = DW'(12'h401 + (k << 4));
      wr_x    = 9'(30 + k);
      wr_data = dk[k];
      cyc();
      acc_k[k] = acc;
      if (last_tick && last_hc == 256) s = k;
      if (!wr_ready) begin rl_cnt++; rl_idx = k; end
      if (line_start) begin ls_cnt++; ls_idx = k; end
    end
    wr_valid = 1'b0;
    chk("ready_low_clks", rl_cnt, 1);
    chk("ready_low_at_swap", rl_idx, s);
    chk("line_start_pulses", ls_cnt, 1);
    chk("line_start_at_swap", ls_idx, s);
    m = 0;
    for (int k = 0; k < 24; k++) if (acc_k[k] != (k != s + 1)) m++;
    chk("accept_pattern", m, 0);
    capture_line();
    chk("pre_swap_write", 32'(cap[30 + s]), 32'(dk[s]));
    m = 0;
    for (int k = 0; k < 24; k++) begin
      e = (k <= s) ? dk[k] : '0;
      if (cap[30 + k] !== e) m++;
    end
    chk("old_bank_line", m, 0);
    capture_line();
    m = 0;
    for (int k = 0; k < 24; k++) begin
      e = (k >= s + 2) ? dk[k] : '0;
      if (cap[30 + k] !== e) m++;
    end
    chk("new_bank_line", m, 0);

    // Reset mid-line with pixels still waiting in the display bank.
    wait_tick(20);
    send(99, 12'h6B7, c);
    send(120, 12'h456, c);
    wr_valid = 1'b0;
    wait_tick(256);
    wait_tick(100);
    chk("pix_before_reset", 32'(pix_out), 32'h6B7);
    reset = 1'b1;
    cyc();
    chk("reset_pix_out", 32'(pix_out), 0);
    chk("reset_wr_ready", 32'(wr_ready), 0);
    cyc();
    cyc();
    reset = 1'b0;
    wait_clear(n);
    chk("reclear_len", n, 512);
    wait_tick(256);
    capture_line();
    chk("post_reset_x120", 32'(cap[120]), 0);
    chk("post_reset_line", count_nonzero(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
